// File: rtl/dm_pkg.sv
// Shared definitions for the multi-cycle data memory.
// Holds the access type codes and the controller state encoding.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_align_ext.sv
// Alignment check, byte-lane mask and load extension for one access.
// Purely combinational; the raw word is the aligned 32-bit word holding the address.
module dm_align_ext
  import dm_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [1:0]  addr_lo,
  input  logic        in_range,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic        err,
  output logic [31:0] ext
);

  logic [31:0] shifted;

  // Lanes are selected by shifting the addressed byte down to bit 0 first.
  always_comb begin
    be      = 4'b0000;
    err     = 1'b0;
    ext     = '0;
    shifted = raw >> {addr_lo, 3'b000};
    case (typ)
      DM_WORD: begin
        be  = 4'b1111;
        err = (addr_lo != 2'b00);
        ext = raw;
      end
      DM_HALF, DM_HALF_U: begin
        be  = 4'b0011 << addr_lo;
        err = addr_lo[0];
        ext = (typ == DM_HALF) ? {{16{shifted[15]}}, shifted[15:0]}
                               : {16'h0000, shifted[15:0]};
      end
      DM_BYTE, DM_BYTE_U: begin
        be  = 4'b0001 << addr_lo;
        ext = (typ == DM_BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                               : {24'h000000, shifted[7:0]};
      end
      default: err = 1'b1;
    endcase
    if (!in_range) begin
      err = 1'b1;
    end
    if (err) begin
      be = 4'b0000;
    end
  end

endmodule

// File: rtl/dm_ctrl.sv
// Multi-cycle byte-addressed data memory with valid/ready request side
// and a single-cycle response pulse after a configurable latency.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_BYTES = 256,
  parameter int LAT         = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_wdata,
  input  logic              dbg_freeze,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic accept, access;

  logic              cap_we, cap_freeze;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_type;
  logic [31:0]       cap_wdata;

  logic [7:0] mem [DEPTH_BYTES];

  logic [IDX_W-1:0] base;
  logic             in_range;
  logic [31:0]      raw, wshift, ext;
  logic [3:0]       be;
  logic             align_err, acc_err, do_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          cnt_next   = 4'(LAT - 1);
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          access     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // Request fields are frozen at accept so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_we     <= 1'b0;
      cap_freeze <= 1'b0;
      cap_addr   <= '0;
      cap_type   <= DM_WORD;
      cap_wdata  <= '0;
    end else if (accept) begin
      cap_we     <= req_we;
      cap_freeze <= dbg_freeze;
      cap_addr   <= req_addr;
      cap_type   <= req_type;
      cap_wdata  <= req_wdata;
    end
  end

  assign in_range = ({1'b0, cap_addr} < (ADDR_W + 1)'(DEPTH_BYTES));
  assign base     = {cap_addr[IDX_W-1:2], 2'b00};
  assign wshift   = cap_wdata << {cap_addr[1:0], 3'b000};

  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      raw[8*k +: 8] = mem[base | IDX_W'(k)];
    end
  end

  dm_align_ext u_align (
    .typ      (cap_type),
    .addr_lo  (cap_addr[1:0]),
    .in_range (in_range),
    .raw      (raw),
    .be       (be),
    .err      (align_err),
    .ext      (ext)
  );

  assign acc_err  = align_err | (cap_we & cap_freeze);
  assign do_write = access & cap_we & ~acc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem[base | IDX_W'(k)] <= wshift[8*k +: 8];
        end
      end
    end
  end

  // Response data holds its value between pulses; stores and errors report zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err | cap_we) ? 32'h0 : ext;
    end
  end

endmodule
